wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port behind the writeback stage. In-order pipeline writeback always wins;

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_arb_fifo.sv | 70 +++++++
 rtl/wb_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: datapath widths, the
// head-ageing state encoding and the LLU result queue entry.
package wb_arb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STARVE = 2'd2
  } wb_arb_state_t;

  // valid=0 marks an entry overwritten by a younger pipeline write; it still
  // occupies its slot until it reaches the head and is popped.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_arb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular store of LLU results. Pointers wrap modulo DEPTH, so any depth
// >= 1 works. A squash clears the valid bit of every stored entry whose
// destination matches; the caller folds same-cycle squash into push_entry_i.
import wb_arb_pkg::*;

module wb_arb_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wb_arb_entry_t     push_entry_i,
  input  logic              pop_i,
  input  logic              squash_i,
  input  logic [REG_AW-1:0] squash_rd_i,
  output wb_arb_entry_t     head_o,
  output logic [CW-1:0]     count_o,
  output logic [CW-1:0]     count_next_o
);

  wb_arb_entry_t   mem_q [DEPTH];
  wb_arb_entry_t   mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (squash_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rd == squash_rd_i) mem_d[i].valid = 1'b0;
      end
    end
    if (push_i) begin
      mem_d[wr_q] = push_entry_i;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop_i) rd_d = ptr_inc(rd_q);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  // Queue state registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_o       = mem_q[rd_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter. Pipeline writeback always wins; LLU
// results queue and drain into idle slots, and a head-ageing FSM raises
// stall_req when the oldest result waits too long.
// Optional feature: define WB_ARB_BYPASS_EN to let an LLU result skip the
// empty queue and write the RF one cycle after llu_valid.
//
// state  | meaning
// IDLE   | queue empty
// WAIT   | queue non-empty, head ageing via wait_cnt
// STARVE | head waited STARVE_LIMIT cycles, stall_req held until it pops
import wb_arb_pkg::*;

module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wb_regwrite,
  input  logic [REG_AW-1:0]                 wb_rd,
  input  logic [XLEN-1:0]                   wb_data,
  input  logic                              llu_valid,
  input  logic [REG_AW-1:0]                 llu_rd,
  input  logic [XLEN-1:0]                   llu_data,
  output logic                              llu_ready,
  output logic                              stall_req,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   llu_pending,
  output logic                              rf_we,
  output logic [REG_AW-1:0]                 rf_waddr,
  output logic [XLEN-1:0]                   rf_wdata
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic               wb_hit;
  logic               bypass;
  logic               push;
  logic               pop;
  wb_arb_entry_t      push_entry;
  wb_arb_entry_t      head;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   fifo_count_next;

  logic               rf_we_q, rf_we_d;
  logic [REG_AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;

  wb_arb_state_t      state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic               stall_q, stall_d;

  // A pipeline write to x0 is treated as an idle slot.
  assign wb_hit    = wb_regwrite && (wb_rd != '0);
  assign llu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

`ifdef WB_ARB_BYPASS_EN
  assign bypass = llu_valid && (fifo_count == '0) && !wb_hit;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (fifo_count != '0) && !wb_hit;
  // LLU results to x0 complete the handshake but are never stored.
  assign push = llu_valid && llu_ready && !bypass && (llu_rd != '0);

  // Entry to enqueue; a same-cycle pipeline write to the same rd is younger.
  always_comb begin
    push_entry.valid = !(wb_hit && (llu_rd == wb_rd));
    push_entry.rd    = llu_rd;
    push_entry.data  = llu_data;
  end

  wb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .squash_i     (wb_hit),
    .squash_rd_i  (wb_rd),
    .head_o       (head),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next)
  );

  // Write-port source select: pipeline, bypass, queue head, else hold.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_hit) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end else if (bypass) begin
      if (llu_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = llu_rd;
        rf_wdata_d = llu_data;
      end
    end else if (pop && head.valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
    end
  end

  assign wait_inc = (wait_q == WAIT_W'(STARVE_LIMIT)) ? wait_q : wait_q + WAIT_W'(1);

  // Head-ageing FSM; wait_cnt restarts whenever a new entry becomes head.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (fifo_count_next == '0) begin
      state_d = IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          wait_d  = '0;
        end
        WAIT: begin
          if (pop) begin
            wait_d = '0;
          end else begin
            if (wait_q == WAIT_W'(STARVE_LIMIT - 1)) state_d = STARVE;
            wait_d = wait_inc;
          end
        end
        STARVE: begin
          if (pop) begin
            state_d = WAIT;
            wait_d  = '0;
          end else begin
            wait_d = wait_inc;
          end
        end
        default: begin
          state_d = IDLE;
          wait_d  = '0;
        end
      endcase
    end
    stall_d = (state_d == STARVE);
  end

  // Output and FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      state_q    <= IDLE;
      wait_q     <= '0;
      stall_q    <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      state_q    <= state_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign stall_req   = stall_q;
  assign llu_pending = fifo_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed plus randomized bench for wb_port_arbiter against a queue-based
// reference model of the arbitration, squash and starvation rules.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              llu_valid;
  logic [REG_AW-1:0] llu_rd;
  logic [XLEN-1:0]   llu_data;
  logic              llu_ready;
  logic              stall_req;
  logic [1:0]        llu_pending;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .llu_valid   (llu_valid),
    .llu_rd      (llu_rd),
    .llu_data    (llu_data),
    .llu_ready   (llu_ready),
    .stall_req   (stall_req),
    .llu_pending (llu_pending),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  typedef struct {
    bit              valid;
    logic [4:0]      rd;
    logic [31:0]     data;
  } ent_t;

  ent_t        mq[$];
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_stall;
  int          m_age;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: advance one clock using the inputs currently driven.
  task automatic model_cycle();
    bit   wb_hit, byp, had_head, popped, ready;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_we = 0; m_waddr = '0; m_wdata = '0; m_stall = 0; m_age = 0;
      return;
    end
    wb_hit   = wb_regwrite && (wb_rd != 0);
    ready    = mq.size() < DEPTH;
    had_head = mq.size() > 0;
    popped   = 0;
    byp      = 0;
`ifdef WB_ARB_BYPASS_EN
    byp = llu_valid && (mq.size() == 0) && !wb_hit;
`endif
    m_we = 0;
    if (wb_hit) begin
      m_we = 1; m_waddr = wb_rd; m_wdata = wb_data;
    end else if (byp) begin
      if (llu_rd != 0) begin
        m_we = 1; m_waddr = llu_rd; m_wdata = llu_data;
      end
    end else if (had_head) begin
      e = mq.pop_front();
      popped = 1;
      if (e.valid) begin
        m_we = 1; m_waddr = e.rd; m_wdata = e.data;
      end
    end
    if (wb_hit) begin
      foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].valid = 0;
    end
    if (llu_valid && ready && !byp && (llu_rd != 0)) begin
      e.valid = !(wb_hit && (llu_rd == wb_rd));
      e.rd    = llu_rd;
      e.data  = llu_data;
      mq.push_back(e);
    end
    if (popped || !had_head) m_age = 0;
    else m_age++;
    m_stall = had_head && !popped && (m_age >= LIMIT);
  endtask

  task automatic check_all();
    chk("rf_we",       rf_we,       m_we);
    chk("rf_waddr",    rf_waddr,    m_waddr);
    chk("rf_wdata",    rf_wdata,    m_wdata);
    chk("stall_req",   stall_req,   m_stall);
    chk("llu_pending", llu_pending, mq.size());
    chk("llu_ready",   llu_ready,   mq.size() < DEPTH);
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit w, input int wrd, input logic [31:0] wd,
                       input bit lv, input int lrd, input logic [31:0] ld);
    wb_regwrite = w;
    wb_rd       = 5'(wrd);
    wb_data     = wd;
    llu_valid   = lv;
    llu_rd      = 5'(lrd);
    llu_data    = ld;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_we", rf_we, 0);
    chk("rst_ready", llu_ready, 1);
    reset = 1'b0;
    step();

    // Pipeline only, then rd 0 as idle slot.
    drive(1, 9, 32'h0fdff262, 0, 0, 0);
    step();
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 9);
    chk("t1_wdata", rf_wdata, 32'h0fdff262);
    drive(1, 0, 32'h12345678, 0, 0, 0);
    step();
    chk("t1_rd0_we", rf_we, 0);
    chk("t1_rd0_hold", rf_wdata, 32'h0fdff262);

    // LLU result into an idle port.
    drive(0, 0, 0, 1, 5, 32'h35c8eb66);
    step();
`ifdef WB_ARB_BYPASS_EN
    chk("t2_byp_we", rf_we, 1);
    chk("t2_byp_pend", llu_pending, 0);
`else
    chk("t2_q_we", rf_we, 0);
    chk("t2_q_pend", llu_pending, 1);
`endif
    drive(0, 0, 0, 0, 0, 0);
    step();
`ifndef WB_ARB_BYPASS_EN
    chk("t2_we", rf_we, 1);
    chk("t2_waddr", rf_waddr, 5);
    chk("t2_wdata", rf_wdata, 32'h35c8eb66);
`endif
    chk("t2_pend", llu_pending, 0);
    step();

    // Full queue and backpressure, then in-order drain.
    drive(1, 20, 32'ha0, 1, 3, 32'h333);
    step();
    drive(1, 21, 32'ha1, 1, 4, 32'h444);
    step();
    chk("t3_full_ready", llu_ready, 0);
    drive(1, 22, 32'ha2, 1, 6, 32'h666);
    step();
    chk("t3_held_pend", llu_pending, 2);
    drive(0, 0, 0, 1, 6, 32'h666);
    step();
    chk("t3_pop1", rf_waddr, 3);
    chk("t3_nopush", llu_pending, 1);
    step();
    chk("t3_pop2", rf_waddr, 4);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t3_pop3", rf_waddr, 6);
    step();

    // Starvation with a continuously busy pipeline.
    drive(1, 20, 32'hb0, 1, 8, 32'h888);
    step();
    drive(1, 21, 32'hb1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("t4_nostall", stall_req, 0);
    step();
    chk("t4_stall", stall_req, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t4_drain_addr", rf_waddr, 8);
    chk("t4_unstall", stall_req, 0);
    step();

    // Squash of a queued entry and of a same-cycle push.
    drive(1, 20, 32'hc0, 1, 7, 32'h76cae447);
    step();
    drive(1, 7, 32'h11, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t5_sq_we", rf_we, 0);
    chk("t5_sq_data", rf_wdata, 32'h11);
    drive(1, 7, 32'h22, 1, 7, 32'h99);
    step();
    chk("t5_same_pend", llu_pending, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t5_same_we", rf_we, 0);
    chk("t5_same_data", rf_wdata, 32'h22);

    // Reset with a full queue in STARVE.
    drive(1, 20, 32'hd0, 1, 10, 32'haaa);
    step();
    drive(1, 21, 32'hd1, 1, 11, 32'hbbb);
    step();
    drive(1, 22, 32'hd2, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t6_pre_stall", stall_req, 1);
    reset = 1'b1;
    step();
    chk("t6_rst_stall", stall_req, 0);
    chk("t6_rst_pend", llu_pending, 0);
    chk("t6_rst_wdata", rf_wdata, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_write", rf_we, 0);
    end

    // Randomized traffic with shifting pipeline load.
    for (int i = 0; i < 3000; i++) begin
      int busy_pct;
      busy_pct = (i < 1000) ? 40 : (i < 2000) ? 85 : 15;
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < busy_pct, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 99) < 50, $urandom_range(0, 7), $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
